// File: rtl/count4_seq_ctrl_if.sv
// count4_seq_ctrl_if: control inputs and status outputs of the sequenced counter
interface count4_seq_ctrl_if #(parameter int WIDTH = 4);
   logic             start;
   logic             pause;
   logic             abort;
   logic             mode;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic [3:0]       wraps;
   modport master (output start, pause, abort, mode, limit, input out, busy, done, wraps);
   modport slave (input start, pause, abort, mode, limit, output out, busy, done, wraps);
endinterface

// File: rtl/count4_seq_ctrl.sv
// count4_seq_ctrl: start/pause/abort sequenced counter with one-shot and auto-reload modes
module count4_seq_ctrl #(parameter int WIDTH = 4) (
   input logic clk,
   input logic reset,
   count4_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_lim;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;
   logic [3:0]       r_wraps;
   // abort outranks pause, and pause outranks the terminal check
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= IDLE;
         r_out <= '0;
         r_lim <= '0;
         r_mode <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_wraps <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE:
               if (bus.start && !bus.abort) begin
                  r_lim <= bus.limit;
                  r_mode <= bus.mode;
                  r_out <= '0;
                  r_wraps <= '0;
                  r_state <= RUN;
                  r_busy <= 1'b1;
               end
            RUN:
               if (bus.abort) begin
                  r_state <= IDLE;
                  r_busy <= 1'b0;
               end else if (bus.pause) begin
                  r_state <= PAUSE;
               end else if (r_out == r_lim) begin
                  r_done <= 1'b1;
                  if (r_mode) begin
                     r_out <= '0;
                     r_wraps <= r_wraps + 4'(r_wraps != 4'hf);
                  end else begin
                     r_state <= IDLE;
                     r_busy <= 1'b0;
                  end
               end else begin
                  r_out <= r_out + WIDTH'(1);
               end
            PAUSE:
               if (bus.abort) begin
                  r_state <= IDLE;
                  r_busy <= 1'b0;
               end else if (!bus.pause) begin
                  r_state <= RUN;
               end
            default: begin
               r_state <= IDLE;
               r_busy <= 1'b0;
            end
         endcase
      end
   assign bus.out = r_out;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.wraps = r_wraps;
endmodule

// File: tb/tb_count4_seq_ctrl.sv
// tb_count4_seq_ctrl: directed self-checking bench for count4_seq_ctrl
module tb_count4_seq_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   count4_seq_ctrl_if #(.WIDTH(4)) bif();
   count4_seq_ctrl #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bif));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic status(input string tag, input int o, input int b, input int d, input int w);
      chk({tag, ".out"}, 32'(bif.out), o);
      chk({tag, ".busy"}, 32'(bif.busy), b);
      chk({tag, ".done"}, 32'(bif.done), d);
      chk({tag, ".wraps"}, 32'(bif.wraps), w);
   endtask
   initial begin
      int ar_out [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
      int ar_done [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
      int pz_pause [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
      int pz_out [8] = '{1, 1, 1, 1, 2, 3, 4, 4};
      int pz_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      bif.start = 1'b0;
      bif.pause = 1'b0;
      bif.abort = 1'b0;
      bif.mode = 1'b0;
      bif.limit = 4'd0;
      #3;
      status("reset", 0, 0, 0, 0);
      #9 reset = 1'b1;
      // one-shot, limit 3
      bif.mode = 1'b0;
      bif.limit = 4'd3;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      bif.limit = 4'd9;
      status("os_e0", 0, 1, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         status($sformatf("os_e%0d", k), k, 1, 0, 0);
      end
      tick();
      status("os_term", 3, 0, 1, 0);
      tick();
      status("os_after", 3, 0, 0, 0);
      // auto-reload, limit 2
      bif.mode = 1'b1;
      bif.limit = 4'd2;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      bif.mode = 1'b0;
      chk("ar_e0.out", 32'(bif.out), ar_out[0]);
      for (int k = 1; k < 9; k++) begin
         tick();
         chk($sformatf("ar_e%0d.out", k), 32'(bif.out), ar_out[k]);
         chk($sformatf("ar_e%0d.done", k), 32'(bif.done), ar_done[k]);
      end
      status("ar_end", 2, 1, 0, 2);
      bif.abort = 1'b1;
      tick();
      bif.abort = 1'b0;
      status("ar_abort", 2, 0, 0, 2);
      // pause for two cycles while out=1
      bif.mode = 1'b0;
      bif.limit = 4'd4;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      status("pz_e0", 0, 1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         bif.pause = pz_pause[k][0];
         tick();
         chk($sformatf("pz_e%0d.out", k + 1), 32'(bif.out), pz_out[k]);
         chk($sformatf("pz_e%0d.done", k + 1), 32'(bif.done), pz_done[k]);
      end
      bif.pause = 1'b0;
      chk("pz_end.busy", 32'(bif.busy), 0);
      // abort on the terminal edge
      bif.limit = 4'd2;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      tick();
      tick();
      status("ab_e2", 2, 1, 0, 0);
      bif.abort = 1'b1;
      tick();
      status("ab_term", 2, 0, 0, 0);
      bif.start = 1'b1;
      tick();
      status("ab_start", 2, 0, 0, 0);
      bif.start = 1'b0;
      bif.abort = 1'b0;
      // pause and abort together: abort wins
      bif.limit = 4'd5;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      bif.pause = 1'b1;
      bif.abort = 1'b1;
      tick();
      status("pa_abort", 0, 0, 0, 0);
      bif.pause = 1'b0;
      bif.abort = 1'b0;
      // reset mid-run, then limit 0 one-shot
      bif.limit = 4'd9;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      status("rs_run", 5, 1, 0, 0);
      reset = 1'b0;
      #1;
      status("rs_async", 0, 0, 0, 0);
      #1 reset = 1'b1;
      bif.limit = 4'd0;
      bif.mode = 1'b0;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      status("l0_e0", 0, 1, 0, 0);
      tick();
      status("l0_e1", 0, 0, 1, 0);
      tick();
      status("l0_e2", 0, 0, 0, 0);
      // auto-reload limit 0: wraps saturation and start-ignore while busy
      bif.mode = 1'b1;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      bif.mode = 1'b0;
      status("sat_e0", 0, 1, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         bif.start = (k >= 3 && k <= 5);
         bif.limit = 4'd7;
         tick();
         chk($sformatf("sat_e%0d.wraps", k), 32'(bif.wraps), (k > 15) ? 15 : k);
         chk($sformatf("sat_e%0d.out", k), 32'(bif.out), 0);
      end
      bif.start = 1'b0;
      status("sat_end", 0, 1, 1, 15);
      bif.abort = 1'b1;
      tick();
      bif.abort = 1'b0;
      status("sat_abort", 0, 0, 0, 15);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/count4_seq_ctrl.md
COUNT4_SEQ_CTRL -- requirements
Module: count4_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, counter and limit width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; clk is the only clock.
REQ-004 Port: start  input  1  run request, sampled on clk edge.
REQ-005 Port: pause  input  1  level; freezes counting while high.
REQ-006 Port: abort  input  1  terminates a run, sampled on clk edge.
REQ-007 Port: mode  input  1  0 = one-shot, 1 = auto-reload.
REQ-008 Port: limit  input  WIDTH  terminal count value.
REQ-009 Port: out  output  WIDTH  current count, registered.
REQ-010 Port: busy  output  1  high while state is RUN or PAUSE, registered.
REQ-011 Port: done  output  1  one-cycle terminal-count pulse, registered.
REQ-012 Port: wraps  output  4  auto-reload wrap count, saturating at 15.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 IDLE, start=1, abort=0 at edge: latch limit to lim_q, latch mode to mode_q, out<=0, wraps<=0, go to RUN.
REQ-015 limit and mode SHALL be ignored outside the start-acceptance edge.
REQ-016 start while busy=1 SHALL be ignored, with no effect on out, lim_q or mode_q.
REQ-017 RUN, pause=0, out!=lim_q: out<=out+1 (modulo 2^WIDTH), stay RUN.
REQ-018 RUN, pause=0, out==lim_q (terminal): done<=1 for exactly one cycle.
REQ-019 Terminal with mode_q=0: go to IDLE; out holds lim_q.
REQ-020 Terminal with mode_q=1: out<=0, stay RUN, wraps<=wraps+1; wraps holds at 15 once it reaches 15.
REQ-021 Latency: start accepted at edge 0 SHALL make out=k after edge k (k<=L, L=lim_q) and assert done after edge L+1.
REQ-022 lim_q=0 is legal: done SHALL assert after edge 1; out stays 0.
REQ-023 RUN, pause=1: go to PAUSE; no increment and no terminal check at that edge.
REQ-024 PAUSE, pause=1: hold all outputs. PAUSE, pause=0: return to RUN with no increment at that edge.
REQ-025 abort=1 in RUN or PAUSE: go to IDLE, out holds its value, done=0 and wraps unchanged.
REQ-026 Priority: abort SHALL win over terminal count and over pause.
REQ-027 abort=1 with start=1 in IDLE: start is ignored and state stays IDLE.
REQ-028 abort=1 in IDLE with start=0: no effect.
REQ-029 done SHALL be 0 in every cycle except the one following a terminal edge.
REQ-030 busy SHALL equal (state != IDLE) as a registered output: it goes to 1 after the start-acceptance edge and to 0 after a one-shot terminal or abort edge.

Reset
REQ-031 reset=0 SHALL immediately, without a clk edge, force state=IDLE, out=0, busy=0, done=0, wraps=0, lim_q=0 and mode_q=0.
REQ-032 Reset asserted mid-run SHALL discard the run; no done pulse is produced.
REQ-033 After reset is released, the first accepted start SHALL behave per REQ-014.

Verification
REQ-034 One-shot: mode=0, limit=3, 1-cycle start -> out 0,1,2,3 on successive edges; done=1 for one cycle after the 5th edge; busy=0 at that point; out stays 3.
REQ-035 Auto-reload: mode=1, limit=2, run 9 edges after start -> out 0,1,2,0,1,2,0,1,2; done pulses after edges 3 and 6; wraps=2.
REQ-036 Pause: one-shot limit=4, pause high for 2 cycles while out=1 -> out=1 for 3 edges, then 2,3,4; done delayed by 3 cycles versus REQ-034 timing.
REQ-037 Abort on terminal: limit=2, abort asserted on the terminal edge -> done stays 0, busy=0, out=2; start in the same cycle as a later abort -> still IDLE.
REQ-038 Reset mid-run: reset=0 while out=5 and busy=1 -> out=0, busy=0, done=0 before the next edge; limit=0 one-shot after release -> done pulse after edge 1.
REQ-039 Wrap saturation and start-ignore: mode=1, limit=0, 20 edges -> wraps=15 and holds; start with limit=7 while busy -> lim_q stays 0.
